// File: rtl/frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frame_gen
//  Purpose  : Parametrised Ethernet test-frame generator for the delay tester
//             TX path. It builds each frame on the fly from DST_MAC, SRC_MAC,
//             ETH_TYPE and a byte-indexed payload, and drives a byte-wide MAC
//             TX port with a dvld/ack handshake. A run emits frame_count
//             frames, or an unbounded stream when frame_count is 0, with
//             GAP_CYCLES idle cycles between frames.
//  Options  : FRAME_GEN_SEQ_EN - when defined, payload bytes 14..17 carry a
//             32-bit per-run frame sequence number, MSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_gen #(
  parameter int          FRAME_LEN  = 60,
  parameter int          GAP_CYCLES = 12,
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h004E_4632_4300,
  parameter logic [15:0] ETH_TYPE   = 16'h88B5
) (
  input  logic        tx_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_count,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_sent
);

  localparam logic [13:0] c_LAST_IDX = 14'(FRAME_LEN - 1);
  localparam logic [15:0] c_GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic        c_JUMBO    = (FRAME_LEN > 1514);
  localparam logic [7:0]  c_BYTE0    = DST_MAC[47:40];

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_DATA     = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t      r_state;
  logic [13:0] r_idx;        // index of the byte currently on mac_tx_data
  logic [15:0] r_gap_cnt;
  logic [15:0] r_remaining;
  logic        r_unbounded;  // run was started with frame_count == 0
`ifdef FRAME_GEN_SEQ_EN
  logic [31:0] r_seq;
`endif

  logic [13:0] w_next_idx;
  logic [7:0]  w_next_byte;

  // Byte that follows the one currently presented; byte 0 is loaded as a constant.
  always_comb begin
    w_next_idx  = r_idx + 14'd1;
    w_next_byte = w_next_idx[7:0];
    case (w_next_idx)
      14'd0:  w_next_byte = DST_MAC[47:40];
      14'd1:  w_next_byte = DST_MAC[39:32];
      14'd2:  w_next_byte = DST_MAC[31:24];
      14'd3:  w_next_byte = DST_MAC[23:16];
      14'd4:  w_next_byte = DST_MAC[15:8];
      14'd5:  w_next_byte = DST_MAC[7:0];
      14'd6:  w_next_byte = SRC_MAC[47:40];
      14'd7:  w_next_byte = SRC_MAC[39:32];
      14'd8:  w_next_byte = SRC_MAC[31:24];
      14'd9:  w_next_byte = SRC_MAC[23:16];
      14'd10: w_next_byte = SRC_MAC[15:8];
      14'd11: w_next_byte = SRC_MAC[7:0];
      14'd12: w_next_byte = ETH_TYPE[15:8];
      14'd13: w_next_byte = ETH_TYPE[7:0];
`ifdef FRAME_GEN_SEQ_EN
      14'd14: w_next_byte = r_seq[31:24];
      14'd15: w_next_byte = r_seq[23:16];
      14'd16: w_next_byte = r_seq[15:8];
      14'd17: w_next_byte = r_seq[7:0];
`endif
      default: w_next_byte = w_next_idx[7:0];
    endcase
  end

  // Frame sequencer: state, byte/gap counters, run bookkeeping and all registered outputs.
  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      r_state            <= S_IDLE;
      r_idx              <= 14'd0;
      r_gap_cnt          <= 16'd0;
      r_remaining        <= 16'd0;
      r_unbounded        <= 1'b0;
`ifdef FRAME_GEN_SEQ_EN
      r_seq              <= 32'd0;
`endif
      conf_tx_en         <= 1'b0;
      conf_tx_jumbo_en   <= 1'b0;
      conf_tx_no_gen_crc <= 1'b0;
      mac_tx_data        <= 8'd0;
      mac_tx_dvld        <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      frames_sent        <= 16'd0;
    end else begin
      conf_tx_en         <= 1'b1;
      conf_tx_jumbo_en   <= c_JUMBO;
      conf_tx_no_gen_crc <= 1'b0;
      done               <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_remaining <= frame_count;
            r_unbounded <= (frame_count == 16'd0);
            frames_sent <= 16'd0;
`ifdef FRAME_GEN_SEQ_EN
            r_seq       <= 32'd0;
`endif
            r_idx       <= 14'd0;
            r_state     <= S_WAIT_ACK;
            mac_tx_dvld <= 1'b1;
            mac_tx_data <= c_BYTE0;
            busy        <= 1'b1;
          end
        end
        S_WAIT_ACK: begin
          // Byte 0 stays on the bus until the MAC accepts it; r_idx is 0 here.
          if (mac_tx_ack) begin
            r_state     <= S_DATA;
            r_idx       <= w_next_idx;
            mac_tx_data <= w_next_byte;
          end
        end
        S_DATA: begin
          if (r_idx == c_LAST_IDX) begin
            r_state     <= S_GAP;
            r_gap_cnt   <= 16'd0;
            mac_tx_dvld <= 1'b0;
            mac_tx_data <= 8'd0;
            frames_sent <= frames_sent + 16'd1;
            if (!r_unbounded) begin
              r_remaining <= r_remaining - 16'd1;
            end
`ifdef FRAME_GEN_SEQ_EN
            r_seq       <= r_seq + 32'd1;
`endif
          end else begin
            r_idx       <= w_next_idx;
            mac_tx_data <= w_next_byte;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            // stop is only looked at here, so a frame is never cut short.
            if (stop || (!r_unbounded && (r_remaining == 16'd0))) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state     <= S_WAIT_ACK;
              r_idx       <= 14'd0;
              mac_tx_dvld <= 1'b1;
              mac_tx_data <= c_BYTE0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
